// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage: opcodes, the ID/EX control word
// layout, the bubble constant and immediate formats.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Field order matches ctrl_e: {alu_op, jump, branch, alu_src, mem_write, mem_read, reg_write}
  typedef struct packed {
    logic [3:0] alu_op;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } imm_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_t kind);
    logic [31:0] imm;
    imm = '0;
    case (kind)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: NREG x XLEN, two combinational read ports,
// one write port, write-first bypass, asynchronous active-high reset.
// x0 reads as zero and ignores writes.
// Ports: clk, reset, ra1/ra2 read indices, rd1/rd2 read data,
//        we/wa/wd write enable, index and data.
module regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = (we && wa == ra1 && ra1 != '0) ? wd : regs[ra1];
    rd2 = (we && wa == ra2 && ra2 != '0) ? wd : regs[ra2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I-subset ID stage: register file, control/immediate decode,
// load-use hazard detection and the ID/EX pipeline register.
// Ports: clk, reset (async, active-high); instr_d/pc4_d from fetch;
//        flush from EX; wb_en/wb_rd/wb_data writeback; ex_mem_read/ex_rd
//        for hazard detection; stall_o to fetch; *_e ID/EX outputs.
// Optional: define DECODE_PERF_EN to add stall_cnt/flush_cnt counters.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc4_d,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic            stall_o,
  output logic [9:0]      ctrl_e,
  output logic [XLEN-1:0] rs1_val_e,
  output logic [XLEN-1:0] rs2_val_e,
  output logic [XLEN-1:0] imm_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] pc4_e
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7_5;
  ctrl_t      ctrl_d;
  imm_t       imm_kind;
  logic       use_rs1, use_rs2;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] rs1_val_d, rs2_val_d, imm_d;
  logic       hazard;

  assign opcode = instr_d[6:0];
  assign f3     = instr_d[14:12];
  assign f7_5   = instr_d[30];

  always_comb begin
    ctrl_d   = BUBBLE;
    imm_kind = IMM_NONE;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = {f7_5, f3};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I_ALU: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_op    = {(f3 == 3'b101) ? f7_5 : 1'b0, f3};
        imm_kind = IMM_I;
        use_rs1  = 1'b1;
      end
      OP_LOAD: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_kind = IMM_I;
        use_rs1  = 1'b1;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_kind = IMM_S;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = {1'b0, f3};
        imm_kind = IMM_B;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_JAL: begin
        ctrl_d.jump      = 1'b1;
        ctrl_d.reg_write = 1'b1;
        imm_kind = IMM_J;
      end
      OP_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_kind = IMM_U;
      end
      default: ;
    endcase
  end

  // Unused source fields read as index 0, so their values fall out as zero
  // and they can never match ex_rd in the hazard check.
  assign rs1_d = use_rs1 ? instr_d[19:15] : '0;
  assign rs2_d = use_rs2 ? instr_d[24:20] : '0;
  assign rd_d  = ctrl_d.reg_write ? instr_d[11:7] : '0;
  assign imm_d = XLEN'(gen_imm(instr_d, imm_kind));

  regfile #(.XLEN(XLEN), .NREG(NREG), .AW(5)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs1_d),
    .ra2   (rs2_d),
    .rd1   (rs1_val_d),
    .rd2   (rs2_val_d),
    .we    (wb_en),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  assign hazard  = ex_mem_read && ex_rd != '0 &&
                   ((use_rs1 && ex_rd == rs1_d) || (use_rs2 && ex_rd == rs2_d));
  assign stall_o = hazard && !flush && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || 1'b0) begin
      ctrl_e    <= '0;
      rs1_val_e <= '0;
      rs2_val_e <= '0;
      imm_e     <= '0;
      rs1_e     <= '0;
      rs2_e     <= '0;
      rd_e      <= '0;
      pc4_e     <= '0;
    end else if (flush || stall_o) begin
      ctrl_e    <= BUBBLE;
      rs1_val_e <= '0;
      rs2_val_e <= '0;
      imm_e     <= '0;
      rs1_e     <= '0;
      rs2_e     <= '0;
      rd_e      <= '0;
      pc4_e     <= '0;
    end else begin
      ctrl_e    <= ctrl_d;
      rs1_val_e <= rs1_val_d;
      rs2_val_e <= rs2_val_d;
      imm_e     <= imm_d;
      rs1_e     <= rs1_d;
      rs2_e     <= rs2_d;
      rd_e      <= rd_d;
      pc4_e     <= pc4_d;
    end
  end

`ifdef DECODE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_o) stall_cnt <= stall_cnt + 32'd1;
      if (flush)   flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d, pc4_d, wb_data;
  logic        flush, wb_en, ex_mem_read;
  logic [4:0]  wb_rd, ex_rd;
  logic        stall_o;
  logic [9:0]  ctrl_e;
  logic [31:0] rs1_val_e, rs2_val_e, imm_e, pc4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  decode_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .pc4_d(pc4_d), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .stall_o(stall_o),
    .ctrl_e(ctrl_e), .rs1_val_e(rs1_val_e), .rs2_val_e(rs2_val_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc4_e(pc4_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic [9:0]  ctrl;
    logic [31:0] rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, exp);
    end
  endtask

  // Monitor: the ID/EX register presents a result after every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "stall_o",   {31'd0, stall_o}, {31'd0, e.stall});
        chk(e.name, "ctrl_e",    {22'd0, ctrl_e},  {22'd0, e.ctrl});
        chk(e.name, "rs1_val_e", rs1_val_e, e.rs1v);
        chk(e.name, "rs2_val_e", rs2_val_e, e.rs2v);
        chk(e.name, "imm_e",     imm_e,     e.imm);
        chk(e.name, "rs1_e",     {27'd0, rs1_e}, {27'd0, e.rs1});
        chk(e.name, "rs2_e",     {27'd0, rs2_e}, {27'd0, e.rs2});
        chk(e.name, "rd_e",      {27'd0, rd_e},  {27'd0, e.rd});
        chk(e.name, "pc4_e",     pc4_e,     e.pc4);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue what the
  // following rising edge must produce.
  task automatic step(input string nm, input logic rst,
                      input logic [31:0] ins, input logic [31:0] pc4,
                      input logic fl, input logic we, input logic [4:0] wrd,
                      input logic [31:0] wdat, input logic emr, input logic [4:0] erd,
                      input logic xs, input logic [9:0] xc,
                      input logic [31:0] xr1v, input logic [31:0] xr2v, input logic [31:0] ximm,
                      input logic [4:0] xr1, input logic [4:0] xr2, input logic [4:0] xrd,
                      input logic [31:0] xpc4);
    exp_t e;
    @(negedge clk);
    reset = rst; instr_d = ins; pc4_d = pc4; flush = fl;
    wb_en = we; wb_rd = wrd; wb_data = wdat; ex_mem_read = emr; ex_rd = erd;
    e.name = nm; e.stall = xs; e.ctrl = xc; e.rs1v = xr1v; e.rs2v = xr2v;
    e.imm = ximm; e.rs1 = xr1; e.rs2 = xr2; e.rd = xrd; e.pc4 = xpc4;
    sb.push_back(e);
  endtask

  localparam logic [31:0] ADD_X3_X5_X0 = 32'h000281B3;
  localparam logic [31:0] ADD_X3_X0_X0 = 32'h000001B3;
  localparam logic [31:0] SW_X5_8_X0   = 32'h00502423;
  localparam logic [31:0] ADDI_X1_M1   = 32'hFFF00093;
  localparam logic [31:0] SRAI_X2_X1_3 = 32'h4030D113;
  localparam logic [31:0] LUI_X4       = 32'hABCDE237;
  localparam logic [31:0] JAL_X1_0     = 32'h000000EF;
  localparam logic [31:0] BEQ_X1_X2_8  = 32'h00208463;

  initial begin
    reset = 1'b1; instr_d = '0; pc4_d = '0; flush = 1'b0; wb_en = 1'b0;
    wb_rd = '0; wb_data = '0; ex_mem_read = 1'b0; ex_rd = '0;

    //   name        rst ins            pc4     fl we wrd wdat          emr erd  | stall ctrl    rs1v          rs2v          imm           r1  r2  rd  pc4
    step("rst_init", 1, ADD_X3_X5_X0, 32'h100, 0, 0, 0, 32'h0,         0, 0,    0, 10'h000, 32'h0,        32'h0,        32'h0,        0,  0,  0,  32'h0);
    step("nop_wr5",  0, 32'h0,        32'h0,   0, 1, 5, 32'hDEADBEEF,  0, 0,    0, 10'h000, 32'h0,        32'h0,        32'h0,        0,  0,  0,  32'h0);
    step("add_rd5",  0, ADD_X3_X5_X0, 32'h104, 0, 0, 0, 32'h0,         0, 0,    0, 10'h001, 32'hDEADBEEF, 32'h0,        32'h0,        5,  0,  3,  32'h104);
    step("bypass",   0, ADD_X3_X5_X0, 32'h108, 0, 1, 5, 32'h12345678,  0, 0,    0, 10'h001, 32'h12345678, 32'h0,        32'h0,        5,  0,  3,  32'h108);
    step("loaduse",  0, ADD_X3_X5_X0, 32'h10C, 0, 0, 0, 32'h0,         1, 5,    1, 10'h000, 32'h0,        32'h0,        32'h0,        0,  0,  0,  32'h0);
    step("exrd0",    0, ADD_X3_X5_X0, 32'h10C, 0, 0, 0, 32'h0,         1, 0,    0, 10'h001, 32'h12345678, 32'h0,        32'h0,        5,  0,  3,  32'h10C);
    step("noload",   0, ADD_X3_X5_X0, 32'h10C, 0, 0, 0, 32'h0,         0, 5,    0, 10'h001, 32'h12345678, 32'h0,        32'h0,        5,  0,  3,  32'h10C);
    step("flushhaz", 0, ADD_X3_X5_X0, 32'h10C, 1, 0, 0, 32'h0,         1, 5,    0, 10'h000, 32'h0,        32'h0,        32'h0,        0,  0,  0,  32'h0);
    step("x0_wr",    0, ADD_X3_X0_X0, 32'h110, 0, 1, 0, 32'hFFFFFFFF,  0, 0,    0, 10'h001, 32'h0,        32'h0,        32'h0,        0,  0,  3,  32'h110);
    step("x0_rd",    0, ADD_X3_X0_X0, 32'h114, 0, 0, 0, 32'h0,         0, 0,    0, 10'h001, 32'h0,        32'h0,        32'h0,        0,  0,  3,  32'h114);
    step("sw_haz",   0, SW_X5_8_X0,   32'h118, 0, 0, 0, 32'h0,         1, 5,    1, 10'h000, 32'h0,        32'h0,        32'h0,        0,  0,  0,  32'h0);
    step("sw",       0, SW_X5_8_X0,   32'h118, 0, 0, 0, 32'h0,         0, 5,    0, 10'h00C, 32'h0,        32'h12345678, 32'h8,        0,  5,  0,  32'h118);
    step("addi_m1",  0, ADDI_X1_M1,   32'h11C, 0, 0, 0, 32'h0,         1, 31,   0, 10'h009, 32'h0,        32'h0,        32'hFFFFFFFF, 0,  0,  1,  32'h11C);
    step("srai",     0, SRAI_X2_X1_3, 32'h120, 0, 0, 0, 32'h0,         0, 0,    0, 10'h349, 32'h0,        32'h0,        32'h403,      1,  0,  2,  32'h120);
    step("instr0",   0, 32'h0,        32'h0,   0, 0, 0, 32'h0,         0, 0,    0, 10'h000, 32'h0,        32'h0,        32'h0,        0,  0,  0,  32'h0);
    step("lui",      0, LUI_X4,       32'h124, 0, 0, 0, 32'h0,         1, 27,   0, 10'h009, 32'h0,        32'h0,        32'hABCDE000, 0,  0,  4,  32'h124);
    step("rst_mid",  1, ADD_X3_X5_X0, 32'h128, 0, 0, 0, 32'h0,         0, 0,    0, 10'h000, 32'h0,        32'h0,        32'h0,        0,  0,  0,  32'h0);
    step("add_post", 0, ADD_X3_X5_X0, 32'h200, 0, 0, 0, 32'h0,         0, 0,    0, 10'h001, 32'h0,        32'h0,        32'h0,        5,  0,  3,  32'h200);
    step("jal",      0, JAL_X1_0,     32'h204, 0, 0, 0, 32'h0,         0, 0,    0, 10'h021, 32'h0,        32'h0,        32'h0,        0,  0,  1,  32'h204);
    step("beq",      0, BEQ_X1_X2_8,  32'h208, 0, 0, 0, 32'h0,         0, 0,    0, 10'h010, 32'h0,        32'h0,        32'h8,        1,  2,  0,  32'h208);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
